// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - time-shared single-MAC FIR stage fed from the sample FIFO
// Pops one sample per result, shifts it into the delay line, then accumulates x[k]*c[k] over TAPS cycles.
module fir_mac #(
    parameter int WIDTH      = 24,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 8,
    parameter int OUT_WIDTH  = WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    output logic                    fifo_pop,
    input  logic [WIDTH-1:0]        fifo_data,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]   coef_data,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int KW = $clog2(TAPS);
    localparam int PW = WIDTH + COEF_WIDTH;
    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, MAC, OUT} state_t;

    state_t state;
    state_t state_nxt;

    logic signed [WIDTH-1:0]      x [TAPS];
    logic signed [COEF_WIDTH-1:0] c [TAPS];
    logic        [KW-1:0]         k;
    logic signed [OUT_WIDTH-1:0]  acc;
    logic signed [OUT_WIDTH-1:0]  acc_sum;
    logic signed [PW-1:0]         prod;
    logic                         last_tap;

    assign prod     = x[k] * c[k];
    assign acc_sum  = acc + {{(OUT_WIDTH - PW){prod[PW-1]}}, prod};
    assign last_tap = (k == K_LAST);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                fifo_pop = !fifo_empty;
                if (!fifo_empty) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: state_nxt = MAC;
            MAC: begin
                if (last_tap) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
            k         <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Coefficients are only writable while no dot product is in flight.
                    if (coef_we) begin
                        c[coef_addr] <= coef_data;
                    end
                end
                WAIT: begin
                    for (int i = TAPS - 1; i > 0; i--) begin
                        x[i] <= x[i-1];
                    end
                    x[0] <= fifo_data;
                    acc  <= '0;
                    k    <= '0;
                end
                MAC: begin
                    acc <= acc_sum;
                    k   <= k + 1'b1;
                    if (last_tap) begin
                        out_data  <= acc_sum;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac.sv
// tb/tb_fir_mac.sv - randomized self-checking bench for fir_mac against a dot-product model
module tb_fir_mac;

    localparam int W  = 24;
    localparam int CW = 16;
    localparam int T  = 8;
    localparam int KW = $clog2(T);
    localparam int OW = W + CW + KW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [W-1:0]  fifo_data = '0;
    logic          coef_we = 1'b0;
    logic [KW-1:0] coef_addr = '0;
    logic [CW-1:0] coef_data = '0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;

    fir_mac #(.WIDTH(W), .COEF_WIDTH(CW), .TAPS(T)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .fifo_data(fifo_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO: data appears the cycle after a pop.
    logic [W-1:0] fmem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_pop && (rd_ptr != wr_ptr)) begin
            fifo_data <= fmem[rd_ptr % 256];
            rd_ptr <= rd_ptr + 1;
        end
    end

    longint m_x [T];
    longint m_c [T];
    logic [OW-1:0] res [64];
    int pop_cyc [64];
    int vld_cyc [64];
    int np, nr;

    function automatic longint sx(input logic [OW-1:0] v);
        logic signed [OW-1:0] t;
        t = v;
        return t;
    endfunction

    function automatic longint model_push(input logic [W-1:0] s);
        longint y;
        logic signed [W-1:0] ss;
        y = 0;
        for (int i = T - 1; i > 0; i--) m_x[i] = m_x[i-1];
        ss = s;
        m_x[0] = ss;
        for (int i = 0; i < T; i++) y += m_x[i] * m_c[i];
        return y;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < T; i++) begin
            m_x[i] = 0;
            m_c[i] = 0;
        end
    endtask

    task automatic fifo_push(input logic [W-1:0] s);
        fmem[wr_ptr % 256] = s;
        wr_ptr++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        coef_we = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input int a, input logic [CW-1:0] v);
        logic signed [CW-1:0] t;
        @(negedge clk);
        coef_we = 1'b1;
        coef_addr = a[KW-1:0];
        coef_data = v;
        t = v;
        m_c[a] = t;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic random_coefs();
        for (int i = 0; i < T; i++) write_coef(i, CW'($urandom));
    endtask

    task automatic wait_valid(output bit to);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        to = !out_valid;
    endtask

    task automatic push_and_get(input logic [W-1:0] s, output logic [OW-1:0] d, output bit to);
        int n;
        @(negedge clk);
        fifo_push(s);
        #1;
        n = 0;
        while (!fifo_pop && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        wait_valid(to);
        d = out_data;
    endtask

    // Records pops and output transfers until n results have been accepted.
    task automatic collect(input int n, input bit rand_ready, output bit to);
        int budget;
        np = 0;
        nr = 0;
        budget = 40 * n + 40;
        while (nr < n && budget > 0) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            if (fifo_pop && np < 64) begin
                pop_cyc[np] = cyc;
                np++;
            end
            if (out_valid && out_ready) begin
                res[nr] = out_data;
                vld_cyc[nr] = cyc;
                nr++;
            end
            if (nr < n) @(negedge clk);
            budget--;
        end
        out_ready = 1'b1;
        to = (nr < n);
    endtask

    task automatic test_reset();
        logic [OW-1:0] d;
        bit to;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || fifo_pop !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b data=%h pop=%b busy=%b, need all 0",
                     out_valid, out_data, fifo_pop, busy);
        end
        reset = 1'b0;
        model_clear();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || fifo_pop !== 1'b0) begin
                failures++;
                $display("FAIL idle_empty: got busy=%b pop=%b, need 0 0", busy, fifo_pop);
            end
        end
        push_and_get(W'($urandom), d, to);
        checks++;
        if (to || sx(d) != 0) begin
            failures++;
            $display("FAIL reset_coefs_zero: got %0d timeout=%b, need 0", sx(d), to);
        end
    endtask

    task automatic test_ramp();
        longint exp [8];
        bit to;
        do_reset();
        for (int i = 0; i < T; i++) write_coef(i, 16'd1);
        for (int i = 1; i <= 8; i++) begin
            fifo_push(W'(i));
            exp[i-1] = model_push(W'(i));
        end
        #1;
        collect(8, 1'b0, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL ramp_timeout: got %0d results, need 8", nr);
        end
        for (int i = 0; i < nr; i++) begin
            checks++;
            if (sx(res[i]) != exp[i] || exp[i] != longint'((i + 1) * (i + 2) / 2)) begin
                failures++;
                $display("FAIL ramp_result[%0d]: got %0d, need %0d", i, sx(res[i]), (i + 1) * (i + 2) / 2);
            end
            checks++;
            if (vld_cyc[i] - pop_cyc[i] != 10) begin
                failures++;
                $display("FAIL ramp_latency[%0d]: got %0d, need 10", i, vld_cyc[i] - pop_cyc[i]);
            end
            if (i > 0) begin
                checks++;
                if (pop_cyc[i] - pop_cyc[i-1] != 11) begin
                    failures++;
                    $display("FAIL ramp_pop_spacing[%0d]: got %0d, need 11", i, pop_cyc[i] - pop_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_impulse();
        logic [OW-1:0] d;
        longint e;
        bit to;
        do_reset();
        for (int i = 0; i < T; i++) write_coef(i, CW'(i + 1));
        for (int i = 0; i < 8; i++) begin
            e = model_push((i == 0) ? W'(1) : W'(0));
            push_and_get((i == 0) ? W'(1) : W'(0), d, to);
            checks++;
            if (to || sx(d) != e || e != longint'(i + 1)) begin
                failures++;
                $display("FAIL impulse[%0d]: got %0d timeout=%b, need %0d", i, sx(d), to, i + 1);
            end
        end
    endtask

    task automatic test_signed();
        logic [OW-1:0] d;
        longint e;
        bit to;
        do_reset();
        write_coef(0, 16'hFFFE);
        e = model_push(24'hFFFFFF);
        push_and_get(24'hFFFFFF, d, to);
        checks++;
        if (to || sx(d) != e || e != 2) begin
            failures++;
            $display("FAIL signed_neg_one: got %0d, need 2", sx(d));
        end
        e = model_push(24'h7FFFFF);
        push_and_get(24'h7FFFFF, d, to);
        checks++;
        if (to || sx(d) != e || e != -64'sd16777214) begin
            failures++;
            $display("FAIL signed_max: got %0d (%h), need -16777214", sx(d), d);
        end
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] held;
        longint e;
        bit to;
        do_reset();
        random_coefs();
        @(negedge clk);
        out_ready = 1'b0;
        e = model_push(W'($urandom));
        fifo_push(W'(m_x[0]));
        wait_valid(to);
        held = out_data;
        checks++;
        if (to || sx(held) != e) begin
            failures++;
            $display("FAIL bp_result: got %0d timeout=%b, need %0d", sx(held), to, e);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || fifo_pop !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: got valid=%b data=%h pop=%b, need 1 %h 0", out_valid, out_data, fifo_pop, held);
            end
        end
        // A queued sample must also wait until the held result is taken.
        e = model_push(W'($urandom));
        fifo_push(W'(m_x[0]));
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (fifo_pop !== 1'b0 || out_data !== held) begin
                failures++;
                $display("FAIL bp_no_pop: got pop=%b data=%h, need 0 %h", fifo_pop, out_data, held);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wait_valid(to);
        checks++;
        if (to || sx(out_data) != e) begin
            failures++;
            $display("FAIL bp_next: got %0d timeout=%b, need %0d", sx(out_data), to, e);
        end
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_pop !== 1'b0) begin
                failures++;
                $display("FAIL bp_after_idle: got valid=%b busy=%b pop=%b, need 0 0 0", out_valid, busy, fifo_pop);
            end
        end
    endtask

    task automatic test_coef_busy();
        logic [OW-1:0] d;
        longint e;
        bit to;
        do_reset();
        for (int i = 0; i < T; i++) write_coef(i, 16'd1);
        @(negedge clk);
        e = model_push(W'($urandom));
        fifo_push(W'(m_x[0]));
        #1;
        @(negedge clk);
        @(negedge clk);
        coef_we = 1'b1;
        coef_addr = '0;
        coef_data = 16'd5;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL coef_busy_state: got busy=%b, need 1", busy);
        end
        @(negedge clk);
        coef_we = 1'b0;
        wait_valid(to);
        checks++;
        if (to || sx(out_data) != e) begin
            failures++;
            $display("FAIL coef_busy_current: got %0d, need %0d", sx(out_data), e);
        end
        e = model_push(W'($urandom));
        push_and_get(W'(m_x[0]), d, to);
        checks++;
        if (to || sx(d) != e) begin
            failures++;
            $display("FAIL coef_busy_later: got %0d, need %0d", sx(d), e);
        end
        write_coef(0, 16'd5);
        e = model_push(W'($urandom));
        push_and_get(W'(m_x[0]), d, to);
        checks++;
        if (to || sx(d) != e) begin
            failures++;
            $display("FAIL coef_idle_write: got %0d, need %0d", sx(d), e);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic [OW-1:0] d;
        longint e;
        bit to;
        do_reset();
        random_coefs();
        e = model_push(W'($urandom));
        push_and_get(W'(m_x[0]), d, to);
        @(negedge clk);
        fifo_push(W'($urandom));
        repeat (4) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || fifo_pop !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got valid=%b data=%h pop=%b busy=%b, need all 0",
                     out_valid, out_data, fifo_pop, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_stale: got valid=%b busy=%b, need 0 0", out_valid, busy);
            end
        end
        e = model_push(W'($urandom));
        push_and_get(W'(m_x[0]), d, to);
        checks++;
        if (to || sx(d) != e || e != 0) begin
            failures++;
            $display("FAIL mid_reset_zero_coefs: got %0d, need 0", sx(d));
        end
        random_coefs();
        e = model_push(W'($urandom));
        push_and_get(W'(m_x[0]), d, to);
        checks++;
        if (to || sx(d) != e) begin
            failures++;
            $display("FAIL mid_reset_zero_line: got %0d, need %0d", sx(d), e);
        end
    endtask

    task automatic test_random_stream();
        longint exp [16];
        bit to;
        random_coefs();
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            exp[i] = model_push(W'($urandom));
            fifo_push(W'(m_x[0]));
        end
        #1;
        collect(16, 1'b1, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL stream_timeout: got %0d results, need 16", nr);
        end
        for (int i = 0; i < nr; i++) begin
            checks++;
            if (sx(res[i]) != exp[i]) begin
                failures++;
                $display("FAIL stream[%0d]: got %0d, need %0d", i, sx(res[i]), exp[i]);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_ramp();
        test_impulse();
        test_signed();
        test_backpressure();
        test_coef_busy();
        test_reset_mid_mac();
        test_random_stream();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
